// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and encodings for the pipeline hazard controller
// Contents: controller state enum and pc_src mux encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance debug
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high clear
//   inc   - add one this cycle (ignored once the count is all-ones)
//   count - current count value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard and sequencing controller for the 5-stage pipeline
// Ports:
//   clk, reset                       - clock, asynchronous active-high reset
//   ifid_rs/ifid_rt                  - source registers of the instruction in ID
//   idex_memread/idex_rt             - load detection for the instruction in EX
//   id_jump                          - jump decoded in ID
//   exmem_beq/exmem_bne/exmem_zero   - branch resolution in MEM
//   mem_req/mem_ready                - data-memory handshake for the instruction in MEM
//   pc_write/ifid_write/pipe_hold    - register load enables / freeze
//   *_flush                          - bubble insertion per pipeline register
//   pc_src                           - next-PC select
//   mem_timeout                      - sticky watchdog error
//   stall_cnt/flush_cnt              - saturating performance counters
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             id_jump,
    input  logic             exmem_beq,
    input  logic             exmem_bne,
    input  logic             exmem_zero,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             pipe_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       pc_src,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WC_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MEM_TIMEOUT);

    state_t          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    logic       taken, loaduse;
    logic       freeze, resolve, redirect;
    logic       pc_write_c, ifid_write_c, pipe_hold_c;
    logic       ifid_flush_c, idex_flush_c, exmem_flush_c, memwb_flush_c;
    logic [1:0] pc_src_c;

    assign taken   = (exmem_beq & exmem_zero) | (exmem_bne & ~exmem_zero);
    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign loaduse = idex_memread && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;
        freeze        = 1'b0;
        resolve       = 1'b0;
        redirect      = 1'b0;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        pipe_hold_c   = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        memwb_flush_c = 1'b0;
        pc_src_c      = PCSRC_SEQ;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WAIT_MAX) begin
                        state_d   = HALT;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    // Branch/jump/load-use held during the wait resolve on the ready cycle.
                    resolve    = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            HALT: begin
                freeze = 1'b1;
            end
            default: begin
                freeze  = 1'b1;
                state_d = RUN;
            end
        endcase

        if (freeze) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            pipe_hold_c   = 1'b1;
            memwb_flush_c = 1'b1;
        end

        if (resolve) begin
            if (taken) begin
                pc_src_c      = PCSRC_BR;
                ifid_flush_c  = 1'b1;
                idex_flush_c  = 1'b1;
                exmem_flush_c = 1'b1;
                redirect      = 1'b1;
            end else if (id_jump) begin
                pc_src_c     = PCSRC_JMP;
                ifid_flush_c = 1'b1;
                redirect     = 1'b1;
            end else if (loaduse) begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                idex_flush_c = 1'b1;
            end
        end
    end

    // Reset forces a safe frozen/flushed pipeline independent of the clock.
    assign pc_write    = reset ? 1'b0 : pc_write_c;
    assign ifid_write  = reset ? 1'b0 : ifid_write_c;
    assign pipe_hold   = reset ? 1'b1 : pipe_hold_c;
    assign ifid_flush  = reset ? 1'b1 : ifid_flush_c;
    assign idex_flush  = reset ? 1'b1 : idex_flush_c;
    assign exmem_flush = reset ? 1'b1 : exmem_flush_c;
    assign memwb_flush = reset ? 1'b1 : memwb_flush_c;
    assign pc_src      = reset ? PCSRC_SEQ : pc_src_c;
    assign mem_timeout = timeout_q;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_write_c),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard testbench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    // ctl = {pc_write, ifid_write, pipe_hold, ifid_flush, idex_flush, exmem_flush, memwb_flush}
    localparam logic [6:0] NORM = 7'b1100000;
    localparam logic [6:0] LU   = 7'b0000100;
    localparam logic [6:0] FRZ  = 7'b0010001;
    localparam logic [6:0] BR   = 7'b1101110;
    localparam logic [6:0] JMP  = 7'b1101000;
    localparam logic [6:0] RST  = 7'b0011111;

    logic       clk = 1'b1;
    logic       reset;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       idex_memread, id_jump, exmem_beq, exmem_bne, exmem_zero;
    logic       mem_req, mem_ready;
    logic       pc_write, ifid_write, pipe_hold;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0] pc_src;
    logic       mem_timeout;
    logic [3:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .id_jump      (id_jump),
        .exmem_beq    (exmem_beq),
        .exmem_bne    (exmem_bne),
        .exmem_zero   (exmem_zero),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .pipe_hold    (pipe_hold),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .memwb_flush  (memwb_flush),
        .pc_src       (pc_src),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    typedef struct {
        int         id;
        logic [6:0] ctl;
        logic [1:0] pcs;
        logic       tmo;
        logic [3:0] s;
        logic [3:0] f;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks  = 0;
    int   errors  = 0;
    int   step_id = 0;

    task automatic push(input logic [6:0] ctl, input logic [1:0] pcs, input logic tmo,
                        input logic [3:0] s, input logic [3:0] f);
        exp_t e;
        e.id  = step_id;
        e.ctl = ctl;
        e.pcs = pcs;
        e.tmo = tmo;
        e.s   = s;
        e.f   = f;
        exp_q.push_back(e);
        step_id++;
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic jmp, input logic beq,
                          input logic bne, input logic z, input logic req, input logic rdy);
        idex_memread = mr;
        idex_rt      = xrt;
        ifid_rs      = rs;
        ifid_rt      = rt;
        id_jump      = jmp;
        exmem_beq    = beq;
        exmem_bne    = bne;
        exmem_zero   = z;
        mem_req      = req;
        mem_ready    = rdy;
    endtask

    task automatic idle;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are compared half a cycle after each input update.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            checks++;
            if ({pc_write, ifid_write, pipe_hold, ifid_flush, idex_flush, exmem_flush,
                 memwb_flush, pc_src, mem_timeout, stall_cnt, flush_cnt} !==
                {cur.ctl, cur.pcs, cur.tmo, cur.s, cur.f}) begin
                errors++;
                $display("FAIL step%0d: got ctl=%b pc_src=%b tmo=%b stall=%0d flush=%0d, expected ctl=%b pc_src=%b tmo=%b stall=%0d flush=%0d",
                         cur.id,
                         {pc_write, ifid_write, pipe_hold, ifid_flush, idex_flush,
                          exmem_flush, memwb_flush},
                         pc_src, mem_timeout, stall_cnt, flush_cnt,
                         cur.ctl, cur.pcs, cur.tmo, cur.s, cur.f);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle();
        #1;
        push(RST, 2'b00, 1'b0, 4'd0, 4'd0);
        next();
        reset = 1'b0;

        // Plain run and load-use
        idle();                                                   push(NORM, 2'b00, 1'b0, 4'd0, 4'd0); next();
        set_in(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 0, 0);            push(LU,   2'b00, 1'b0, 4'd0, 4'd0); next();
        idle();                                                   push(NORM, 2'b00, 1'b0, 4'd1, 4'd0); next();
        set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);            push(NORM, 2'b00, 1'b0, 4'd1, 4'd0); next();
        set_in(1, 5'd5, 5'd3, 5'd5, 0, 0, 0, 0, 0, 0);            push(LU,   2'b00, 1'b0, 4'd1, 4'd0); next();

        // Branch over jump, bne cases, jump over load-use, zero-wait access
        set_in(0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 1, 0, 0);            push(BR,   2'b01, 1'b0, 4'd2, 4'd0); next();
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);            push(NORM, 2'b00, 1'b0, 4'd2, 4'd1); next();
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);            push(BR,   2'b01, 1'b0, 4'd2, 4'd1); next();
        set_in(1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0, 0, 0);            push(JMP,  2'b10, 1'b0, 4'd2, 4'd2); next();
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);            push(NORM, 2'b00, 1'b0, 4'd2, 4'd3); next();

        // Three-cycle memory wait
        for (int i = 0; i < 3; i++) begin
            set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);        push(FRZ,  2'b00, 1'b0, 4'(2 + i), 4'd3); next();
        end
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);            push(NORM, 2'b00, 1'b0, 4'd5, 4'd3); next();
        idle();                                                   push(NORM, 2'b00, 1'b0, 4'd5, 4'd3); next();

        // Taken branch held across a two-cycle wait
        for (int i = 0; i < 2; i++) begin
            set_in(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1, 0);        push(FRZ,  2'b00, 1'b0, 4'(5 + i), 4'd3); next();
        end
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1, 1);            push(BR,   2'b01, 1'b0, 4'd7, 4'd3); next();
        idle();                                                   push(NORM, 2'b00, 1'b0, 4'd7, 4'd4); next();

        // Watchdog: one RUN freeze cycle plus four MEM_WAIT cycles, then HALT
        for (int i = 0; i < 5; i++) begin
            set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);        push(FRZ,  2'b00, 1'b0, 4'(7 + i), 4'd4); next();
        end
        // HALT ignores mem_ready and branches; stall counter saturates at 15
        for (int i = 0; i < 6; i++) begin
            set_in(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1, 1);
            push(FRZ, 2'b00, 1'b1, (12 + i > 15) ? 4'd15 : 4'(12 + i), 4'd4);
            next();
        end

        // Reset leaves HALT
        reset = 1'b1;
        idle();                                                   push(RST,  2'b00, 1'b0, 4'd0, 4'd0); next();
        reset = 1'b0;

        // Asynchronous reset in the middle of a MEM_WAIT cycle
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);            push(FRZ,  2'b00, 1'b0, 4'd0, 4'd0); next();
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);            push(FRZ,  2'b00, 1'b0, 4'd1, 4'd0); next();
        #2;
        reset = 1'b1;
        push(RST, 2'b00, 1'b0, 4'd0, 4'd0);
        next();
        reset = 1'b0;
        idle();                                                   push(NORM, 2'b00, 1'b0, 4'd0, 4'd0); next();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
